// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the 16-bit core's decode/issue stage.
//   - opcode constants 0..15 (12..15 are illegal)
//   - alusignals bit indices (one-hot ALU control word)
//   - FLAGS_REG: architectural register written by cmp
//   - instruction field offsets
//   - decode_t / decode_inst(): field extraction plus source/destination usage
package core_pkg;

    localparam int NALU      = 12;
    localparam int FLAGS_REG = 7;

    // Instruction field offsets
    localparam int OPC_LSB  = 12;
    localparam int RD_LSB   = 9;
    localparam int RS1_LSB  = 6;
    localparam int IMM_BIT  = 5;
    localparam int RS2_LSB  = 2;

    // Opcodes
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_LD  = 4'd1;
    localparam logic [3:0] OP_ST  = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_LSL = 4'd10;
    localparam logic [3:0] OP_LSR = 4'd11;
    localparam logic [3:0] OP_I12 = 4'd12;
    localparam logic [3:0] OP_I13 = 4'd13;
    localparam logic [3:0] OP_I14 = 4'd14;
    localparam logic [3:0] OP_I15 = 4'd15;

    // alusignals bit indices
    localparam int ALU_ADD = 0;
    localparam int ALU_LD  = 1;
    localparam int ALU_ST  = 2;
    localparam int ALU_SUB = 3;
    localparam int ALU_MUL = 4;
    localparam int ALU_CMP = 5;
    localparam int ALU_MOV = 6;
    localparam int ALU_OR  = 7;
    localparam int ALU_AND = 8;
    localparam int ALU_NOT = 9;
    localparam int ALU_LSL = 10;
    localparam int ALU_LSR = 11;

    typedef struct packed {
        logic [3:0] opc;
        logic       legal;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       imm;
        logic [4:0] imm5;
        logic       use_rs1;
        logic       use_rs2;
        logic       use_rd;    // st reads rd as store data
        logic       has_dest;
        logic [2:0] dest;      // cmp always targets the flags register
    } decode_t;

    function automatic decode_t decode_inst(input logic [15:0] inst);
        decode_t d;
        d.opc      = inst[OPC_LSB +: 4];
        d.rd       = inst[RD_LSB +: 3];
        d.rs1      = inst[RS1_LSB +: 3];
        d.rs2      = inst[RS2_LSB +: 3];
        d.imm      = inst[IMM_BIT];
        d.imm5     = inst[4:0];
        d.legal    = (d.opc <= OP_LSR);
        d.use_rs1  = d.legal && (d.opc != OP_MOV);
        d.use_rs2  = d.legal && !d.imm && (d.opc != OP_NOT);
        d.use_rd   = d.legal && (d.opc == OP_ST);
        d.has_dest = d.legal && (d.opc != OP_ST);
        d.dest     = (d.opc == OP_CMP) ? 3'(FLAGS_REG) : d.rd;
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_scoreboard.sv
// issue_scoreboard: per-register busy bits for ALU results in flight and the
// resulting issue stall.
//   clk, rst_n   : clock, async active-low reset (clears every busy bit)
//   src_mask     : one bit per register read by the presented instruction
//   dst_chk/dst  : presented instruction writes register dst (WAW check)
//   set_en       : instruction accepted this cycle; mark dst busy
//   wb_en/wb_rd  : writeback returning; clear busy[wb_rd] (a same-cycle set wins)
//   stall        : a used source or the destination is still busy
// Optional macro ALU_ISSUE_WB_BYPASS_EN: a register being written back this
// cycle is treated as free for the stall decision.
module issue_scoreboard #(
    parameter int NREGS = 8,
    parameter int RW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREGS-1:0] src_mask,
    input  logic             dst_chk,
    input  logic [RW-1:0]    dst,
    input  logic             set_en,
    input  logic             wb_en,
    input  logic [RW-1:0]    wb_rd,
    output logic             stall
);

    logic [NREGS-1:0] busy, busy_n, busy_eff, wb_hit;

    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < NREGS; i++)
            wb_hit[i] = wb_en && (wb_rd == RW'(i));
    end

`ifdef ALU_ISSUE_WB_BYPASS_EN
    assign busy_eff = busy & ~wb_hit;
`else
    assign busy_eff = busy;
`endif

    assign stall = (|(src_mask & busy_eff)) || (dst_chk && busy_eff[dst]);

    always_comb begin
        busy_n = busy;
        for (int i = 0; i < NREGS; i++) begin
            if (wb_hit[i])
                busy_n[i] = 1'b0;
            if (set_en && (dst == RW'(i)))
                busy_n[i] = 1'b1;   // set after clear: set wins
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_n;
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage feeding the execute-stage ALU.
//   clk, rst_n        : clock, async active-low reset
//   inst_valid/inst   : instruction from fetch; inst_ready = accept this cycle
//   alusignals        : one-hot ALU control (0 on bubble)
//   op1/op2/immx      : operands / unextended imm5, isimmediate selects immx as B
//   st_data           : reg[rd] for st
//   issue_rd          : destination tag (7 for cmp)
//   issue_valid       : issue registers hold a real op
//   wb_en/wb_rd/wb_data : ALU writeback into the register file
//   illegal_op        : one-cycle pulse when opcode 12..15 is consumed
// Optional macro ALU_ISSUE_WB_BYPASS_EN: operands read wb_data when the source
// matches a same-cycle writeback, and that register no longer stalls.
module alu_issue
    import core_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int XLEN  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    input  logic [15:0]     inst,
    output logic            inst_ready,
    output logic [11:0]     alusignals,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [4:0]      immx,
    output logic            isimmediate,
    output logic [XLEN-1:0] st_data,
    output logic [2:0]      issue_rd,
    output logic            issue_valid,
    input  logic            wb_en,
    input  logic [2:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            illegal_op
);

    decode_t          d;
    logic [NREGS-1:0] src_mask;
    logic [11:0]      alu_dec;
    logic             stall, accept;
    logic [XLEN-1:0]  rf [NREGS];
    logic [XLEN-1:0]  rs1_val, rs2_val, rd_val;

    assign d = decode_inst(inst);

    always_comb begin
        src_mask = '0;
        if (d.use_rs1) src_mask[d.rs1] = 1'b1;
        if (d.use_rs2) src_mask[d.rs2] = 1'b1;
        if (d.use_rd)  src_mask[d.rd]  = 1'b1;
    end

    always_comb begin
        alu_dec = '0;
        case (d.opc)
            OP_ADD:  alu_dec[ALU_ADD] = 1'b1;
            OP_LD:   alu_dec[ALU_LD]  = 1'b1;
            OP_ST:   alu_dec[ALU_ST]  = 1'b1;
            OP_SUB:  alu_dec[ALU_SUB] = 1'b1;
            OP_MUL:  alu_dec[ALU_MUL] = 1'b1;
            OP_CMP:  alu_dec[ALU_CMP] = 1'b1;
            OP_MOV:  alu_dec[ALU_MOV] = 1'b1;
            OP_OR:   alu_dec[ALU_OR]  = 1'b1;
            OP_AND:  alu_dec[ALU_AND] = 1'b1;
            OP_NOT:  alu_dec[ALU_NOT] = 1'b1;
            OP_LSL:  alu_dec[ALU_LSL] = 1'b1;
            OP_LSR:  alu_dec[ALU_LSR] = 1'b1;
            default: alu_dec = '0;   // 12..15: illegal, bubble
        endcase
    end

    // Illegal opcodes decode with no sources and no destination, so they
    // never stall and never touch the scoreboard.
    issue_scoreboard #(.NREGS(NREGS), .RW(3)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_mask (src_mask),
        .dst_chk  (d.has_dest),
        .dst      (d.dest),
        .set_en   (accept && d.has_dest),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .stall    (stall)
    );

    assign inst_ready = !stall;
    assign accept     = inst_valid && inst_ready;

    // Register file: combinational read, written at the edge on writeback.
    always_comb begin
        rs1_val = rf[d.rs1];
        rs2_val = rf[d.rs2];
        rd_val  = rf[d.rd];
`ifdef ALU_ISSUE_WB_BYPASS_EN
        if (wb_en) begin
            if (wb_rd == d.rs1) rs1_val = wb_data;
            if (wb_rd == d.rs2) rs2_val = wb_data;
            if (wb_rd == d.rd)  rd_val  = wb_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (wb_en) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Issue registers: a bubble clears only alusignals/issue_valid; operand
    // fields hold so the ALU inputs do not toggle needlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alusignals  <= '0;
            issue_valid <= 1'b0;
            op1         <= '0;
            op2         <= '0;
            st_data     <= '0;
            immx        <= '0;
            isimmediate <= 1'b0;
            issue_rd    <= '0;
            illegal_op  <= 1'b0;
        end else begin
            illegal_op <= accept && !d.legal;
            if (accept && d.legal) begin
                alusignals  <= alu_dec;
                issue_valid <= 1'b1;
                op1         <= rs1_val;
                op2         <= rs2_val;
                st_data     <= rd_val;
                immx        <= d.imm5;
                isimmediate <= d.imm;
                issue_rd    <= d.dest;
            end else begin
                alusignals  <= '0;
                issue_valid <= 1'b0;
            end
        end
    end

endmodule
